// File: rtl/data_mem_arbiter_pkg.sv
// Shared types and defaults for the data memory arbiter.
// State encoding plus default widths and the starvation limit.
package data_mem_arbiter_pkg;

  localparam int ADDR_W_D       = 8;
  localparam int DATA_W_D       = 32;
  localparam int STARVE_LIMIT_D = 4;
  localparam int CNT_W          = 4;

  typedef enum logic {
    S_NORMAL = 1'b0,
    S_FORCE  = 1'b1
  } arb_state_e;

endpackage

// File: rtl/arb_starve_counter.sv
// Counts consecutive denied ext cycles, saturating at LIMIT.
// limit_hit flags that the count reaches LIMIT at the coming edge.
module arb_starve_counter
  import data_mem_arbiter_pkg::*;
#(
  parameter int LIMIT = STARVE_LIMIT_D
) (
  input  logic clk,
  input  logic rst_n,
  input  logic inc,
  input  logic clear,
  output logic limit_hit
);

  localparam logic [CNT_W-1:0] LIM = CNT_W'(LIMIT);

  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (clear)
      cnt_nxt = '0;
    else if (inc && cnt < LIM)
      cnt_nxt = cnt + 1'b1;
  end

  assign limit_hit = (cnt_nxt == LIM);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      cnt <= '0;
    else
      cnt <= cnt_nxt;
  end

endmodule

// File: rtl/data_mem_arbiter.sv
// Single-port data memory arbiter: pipe has priority,
// ext gets a forced slot after sustained denial.
module data_mem_arbiter
  import data_mem_arbiter_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_D,
  parameter int DATA_W       = DATA_W_D,
  parameter int STARVE_LIMIT = STARVE_LIMIT_D
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              pipe_rd,
  input  logic              pipe_wr,
  input  logic [31:0]       pipe_addr,
  input  logic [DATA_W-1:0] pipe_wdata,
  output logic [DATA_W-1:0] pipe_rdata,
  output logic              pipe_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              ext_rvalid,
  output logic              mem_rd,
  output logic              mem_wr,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  arb_state_e state;
  logic       pipe_act;
  logic       force_slot;
  logic       pipe_own;
  logic       ext_own;
  logic       limit_hit;
  logic       unused_addr;

  assign unused_addr = ^pipe_addr[31:ADDR_W];

  assign pipe_act   = pipe_rd | pipe_wr;
  assign force_slot = (state == S_FORCE);
  assign pipe_own   = ~force_slot & pipe_act;
  assign ext_own    = ext_req & (force_slot | ~pipe_act);
  assign ext_gnt    = ext_own;
  assign pipe_stall = force_slot & pipe_act;

  arb_starve_counter #(
    .LIMIT (STARVE_LIMIT)
  ) u_starve (
    .clk       (clk),
    .rst_n     (rst_n),
    .inc       (ext_req & ~ext_own),
    .clear     (force_slot | ext_own | ~ext_req),
    .limit_hit (limit_hit)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_NORMAL;
    end else begin
      unique case (state)
        S_NORMAL: if (limit_hit) state <= S_FORCE;
        S_FORCE:  state <= S_NORMAL;
        default:  state <= S_NORMAL;
      endcase
    end
  end

  always_comb begin
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    unique case (1'b1)
      pipe_own: begin
        mem_rd    = pipe_rd;
        mem_wr    = pipe_wr;
        mem_addr  = pipe_addr[ADDR_W-1:0];
        mem_wdata = pipe_wdata;
      end
      ext_own: begin
        mem_rd    = ~ext_we;
        mem_wr    = ext_we;
        mem_addr  = ext_addr;
        mem_wdata = ext_wdata;
      end
      default: ;
    endcase
  end

  assign pipe_rdata = (pipe_own && pipe_rd) ? mem_rdata : '0;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ext_rdata  <= '0;
      ext_rvalid <= 1'b0;
    end else begin
      ext_rvalid <= ext_own & ~ext_we;
      if (ext_own && !ext_we)
        ext_rdata <= mem_rdata;
    end
  end

endmodule

// File: tb/tb_data_mem_arbiter.sv
// Directed bench for data_mem_arbiter with a behavioural memory
// and a scoreboard for ext read returns.
module tb_data_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        pipe_rd, pipe_wr;
  logic [31:0] pipe_addr, pipe_wdata, pipe_rdata;
  logic        pipe_stall;
  logic        ext_req, ext_we;
  logic [7:0]  ext_addr;
  logic [31:0] ext_wdata, ext_rdata;
  logic        ext_gnt, ext_rvalid;
  logic        mem_rd, mem_wr;
  logic [7:0]  mem_addr;
  logic [31:0] mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;
  logic [31:0] exp_q[$];
  logic [31:0] mem[256];

  always #5 clk = ~clk;

  data_mem_arbiter dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .pipe_rd    (pipe_rd),
    .pipe_wr    (pipe_wr),
    .pipe_addr  (pipe_addr),
    .pipe_wdata (pipe_wdata),
    .pipe_rdata (pipe_rdata),
    .pipe_stall (pipe_stall),
    .ext_req    (ext_req),
    .ext_we     (ext_we),
    .ext_addr   (ext_addr),
    .ext_wdata  (ext_wdata),
    .ext_gnt    (ext_gnt),
    .ext_rdata  (ext_rdata),
    .ext_rvalid (ext_rvalid),
    .mem_rd     (mem_rd),
    .mem_wr     (mem_wr),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  assign mem_rdata = mem[mem_addr];
  always @(posedge clk) if (mem_wr) mem[mem_addr] <= mem_wdata;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Scoreboard monitor for ext read returns
  always @(negedge clk) begin
    if (rst_n === 1'b1 && ext_rvalid === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ext_rvalid: got data %h expected no pulse",
                 ext_rdata);
      end else begin
        logic [31:0] e;
        e = exp_q.pop_front();
        if (ext_rdata !== e) begin
          errors++;
          $display("FAIL ext_rdata: got %h expected %h", ext_rdata, e);
        end
      end
    end
  end

  task automatic drv(input logic prd, input logic pwr,
                     input logic [31:0] pa, input logic [31:0] pd,
                     input logic er, input logic ew,
                     input logic [7:0] ea, input logic [31:0] ed);
    pipe_rd = prd; pipe_wr = pwr; pipe_addr = pa; pipe_wdata = pd;
    ext_req = er; ext_we = ew; ext_addr = ea; ext_wdata = ed;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = '0;
    rst_n = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_rvalid", ext_rvalid, 0);
    chk("rst_rdata", ext_rdata, 0);
    chk("rst_mem_rd", mem_rd, 0);
    rst_n = 1'b1;
    nxt();

    // ext only: write then read back
    drv(0, 0, 0, 0, 1, 1, 8'h10, 32'hDEADBEEF);
    @(negedge clk);
    chk("ext_wr_gnt", ext_gnt, 1);
    chk("ext_wr_mem_wr", mem_wr, 1);
    chk("ext_wr_addr", mem_addr, 32'h10);
    chk("ext_wr_wdata", mem_wdata, 32'hDEADBEEF);
    nxt();
    drv(0, 0, 0, 0, 1, 0, 8'h10, 0);
    exp_q.push_back(32'hDEADBEEF);
    @(negedge clk);
    chk("ext_rd_gnt", ext_gnt, 1);
    chk("ext_rd_mem_rd", mem_rd, 1);
    nxt();

    // idle
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("idle_mem_rd", mem_rd, 0);
    chk("idle_mem_wr", mem_wr, 0);
    chk("idle_addr", mem_addr, 0);
    chk("idle_prdata", pipe_rdata, 0);
    chk("idle_gnt", ext_gnt, 0);
    nxt();

    // pipe only
    drv(0, 1, 32'h0000_0105, 7, 0, 0, 0, 0);
    @(negedge clk);
    chk("pwr_addr", mem_addr, 32'h05);
    chk("pwr_mem_wr", mem_wr, 1);
    chk("pwr_stall", pipe_stall, 0);
    nxt();
    drv(1, 0, 32'h05, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("prd_addr", mem_addr, 32'h05);
    chk("prd_rdata", pipe_rdata, 7);
    chk("prd_stall", pipe_stall, 0);
    nxt();

    // starvation pattern, period 5
    for (int i = 1; i <= 10; i++) begin
      drv(1, 0, 32'h05, 0, 1, 0, 8'h10, 0);
      if (i % 5 == 0) exp_q.push_back(32'hDEADBEEF);
      @(negedge clk);
      chk($sformatf("starve_gnt%0d", i), ext_gnt, (i % 5 == 0));
      chk($sformatf("starve_stall%0d", i), pipe_stall, (i % 5 == 0));
      chk($sformatf("starve_prdata%0d", i), pipe_rdata,
          (i % 5 == 0) ? 0 : 7);
      nxt();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    nxt();

    // forced slot with ext dropping its request
    for (int i = 1; i <= 4; i++) begin
      drv(1, 0, 32'h05, 0, 1, 0, 8'h10, 0);
      @(negedge clk);
      chk($sformatf("drop_gnt%0d", i), ext_gnt, 0);
      nxt();
    end
    drv(1, 0, 32'h05, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("drop_force_gnt", ext_gnt, 0);
    chk("drop_force_stall", pipe_stall, 1);
    chk("drop_force_rd", mem_rd, 0);
    chk("drop_force_wr", mem_wr, 0);
    nxt();
    @(negedge clk);
    chk("drop_after_stall", pipe_stall, 0);
    chk("drop_after_rdata", pipe_rdata, 7);
    nxt();

    // ext write visible to next-cycle pipe read
    drv(0, 0, 0, 0, 1, 1, 8'h20, 32'h55);
    @(negedge clk);
    chk("ew_gnt", ext_gnt, 1);
    nxt();
    drv(1, 0, 32'h20, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("ew_prd", pipe_rdata, 32'h55);
    nxt();

    // simultaneous pipe read and write returns old data
    drv(1, 1, 32'h20, 32'h66, 0, 0, 0, 0);
    @(negedge clk);
    chk("rw_rdata", pipe_rdata, 32'h55);
    chk("rw_mem_wr", mem_wr, 1);
    chk("rw_mem_rd", mem_rd, 1);
    nxt();
    drv(1, 0, 32'h20, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("rw_new", pipe_rdata, 32'h66);
    nxt();

    // async reset while an ext read return is pending
    drv(0, 0, 0, 0, 1, 0, 8'h10, 0);
    @(negedge clk);
    chk("rst_rd_gnt", ext_gnt, 1);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rvalid", ext_rvalid, 0);
    chk("async_rdata", ext_rdata, 0);
    chk("async_mem_wr", mem_wr, 0);
    drv(0, 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk);
    chk("async_rvalid2", ext_rvalid, 0);
    rst_n = 1'b1;
    nxt();

    for (int i = 0; i < 10 && exp_q.size() != 0; i++) nxt();
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending reads expected 0",
               exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end

endmodule
